// File: rtl/edge_binarize_pack.sv
// Thresholds Sobel gradient magnitudes to 1-bit edge flags and packs them LSB-first
// into output words. Words go out through a FWFT FIFO; the per-frame max sets the auto threshold.
module edge_binarize_pack #(
    parameter int ROI_SIZE            = 480,
    parameter int PIXELS_IN_PER_CYCLE = 2,
    parameter int IN_WIDTH            = 12,
    parameter int PORT_BITS           = 128,
    parameter int FIFO_DEPTH          = 8,
    parameter int THR_SHIFT           = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                clk_en,
    input  logic                                                in_valid,
    input  logic signed [PIXELS_IN_PER_CYCLE-1:0][IN_WIDTH-1:0] data_in,
    input  logic                                                thr_sel,
    input  logic        [IN_WIDTH-1:0]                          thr_in,
    input  logic                                                ovf_clr,
    output logic        [PORT_BITS-1:0]                         out_data,
    output logic                                                out_valid,
    output logic                                                out_last,
    input  logic                                                out_ready,
    output logic                                                frame_done,
    output logic        [IN_WIDTH-1:0]                          frame_max,
    output logic                                                overflow
);

    localparam int P         = PIXELS_IN_PER_CYCLE;
    localparam int FRAME_PIX = ROI_SIZE * ROI_SIZE;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);
    localparam int BP_W      = (PORT_BITS > 1) ? $clog2(PORT_BITS) : 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = AW + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    function automatic logic signed [IN_WIDTH-1:0] smax(
        input logic signed [IN_WIDTH-1:0] a,
        input logic signed [IN_WIDTH-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    state_t                       state_p0, state_nxt;
    logic signed [IN_WIDTH-1:0]   thr_p0;
    logic        [PORT_BITS-1:0]  pack_p0;
    logic        [BP_W-1:0]       bit_ptr_p0;
    logic        [PIX_W-1:0]      pix_cnt_p0;
    logic signed [IN_WIDTH-1:0]   run_max_p0;
    logic signed [IN_WIDTH-1:0]   prev_max_p0;
    logic signed [IN_WIDTH-1:0]   frame_max_p1;
    logic                         frame_done_p1;

    logic                         beat;
    logic signed [IN_WIDTH-1:0]   thr_new;
    logic signed [IN_WIDTH-1:0]   thr_use;
    logic        [P-1:0]          flags;
    logic signed [IN_WIDTH-1:0]   beat_max;
    logic signed [IN_WIDTH-1:0]   max_next;
    logic                         word_full;
    logic                         frame_end;
    logic        [PORT_BITS-1:0]  pack_next;

    logic                         push;
    logic                         push_last;
    logic        [PORT_BITS-1:0]  push_data;
    logic                         frame_push;

    // ---- stage p0: threshold, flag generation and packing ----
    assign beat      = clk_en & in_valid & (state_p0 != FLUSH);
    assign thr_new   = thr_sel ? (prev_max_p0 >>> THR_SHIFT) : $signed(thr_in);
    assign thr_use   = (state_p0 == IDLE) ? thr_new : thr_p0;
    assign word_full = (bit_ptr_p0 == BP_W'(PORT_BITS - P));
    assign frame_end = (pix_cnt_p0 == PIX_W'(FRAME_PIX - P));

    always_comb begin
        flags    = '0;
        beat_max = $signed(data_in[0]);
        for (int n = 0; n < P; n++) begin
            flags[n] = ($signed(data_in[n]) > thr_use);
            beat_max = smax(beat_max, $signed(data_in[n]));
        end
    end

    assign pack_next = pack_p0 | (PORT_BITS'(flags) << bit_ptr_p0);
    assign max_next  = beat ? smax(run_max_p0, beat_max) : run_max_p0;

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE, ACTIVE: begin
                if (beat) begin
                    if (frame_end) state_nxt = word_full ? IDLE : FLUSH;
                    else           state_nxt = ACTIVE;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_data = pack_next;
        case (state_p0)
            FLUSH: begin
                push      = clk_en;
                push_last = 1'b1;
                push_data = pack_p0;
            end
            default: begin
                push      = beat & word_full;
                push_last = frame_end;
            end
        endcase
        frame_push = push & push_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0      <= IDLE;
            thr_p0        <= '0;
            pack_p0       <= '0;
            bit_ptr_p0    <= '0;
            pix_cnt_p0    <= '0;
            run_max_p0    <= '0;
            prev_max_p0   <= '0;
            frame_max_p1  <= '0;
            frame_done_p1 <= 1'b0;
        end else if (clk_en) begin
            state_p0      <= state_nxt;
            frame_done_p1 <= frame_push;
            if (beat) begin
                if (state_p0 == IDLE) thr_p0 <= thr_new;
                pack_p0    <= word_full ? '0 : pack_next;
                bit_ptr_p0 <= word_full ? '0 : bit_ptr_p0 + BP_W'(P);
                pix_cnt_p0 <= frame_end ? '0 : pix_cnt_p0 + PIX_W'(P);
            end else if (state_p0 == FLUSH) begin
                pack_p0    <= '0;
                bit_ptr_p0 <= '0;
            end
            // The frame-end push folds the final beat into the max before it is published.
            if (frame_push) begin
                frame_max_p1 <= max_next;
                prev_max_p0  <= max_next;
                run_max_p0   <= '0;
            end else if (beat) begin
                run_max_p0   <= max_next;
            end
        end
    end

    assign frame_done = frame_done_p1;
    assign frame_max  = frame_max_p1;

    // ---- stage p1: first-word-fall-through output FIFO ----
    logic [PORT_BITS-1:0] mem_data [FIFO_DEPTH];
    logic                 mem_last [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 full, pop, push_ok, ovf_set, ovf_q;

    assign out_valid = (fifo_cnt != '0);
    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready & clk_en;
    assign push_ok   = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ovf_set)                 ovf_q <= 1'b1;
            else if (clk_en && ovf_clr)  ovf_q <= 1'b0;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;
    assign overflow = ovf_q;

endmodule

// File: doc/edge_binarize_pack.md
Name: edge_binarize_pack

Overview:
- Directly downstream of the Sobel convolution stage.
- Consumes PIXELS_IN_PER_CYCLE gradient magnitudes per valid beat and thresholds each one to a 1-bit edge flag.
- Packs the flags LSB-first into PORT_BITS-wide words and buffers them in a small FIFO.
- Feeds the output port / DMA writer through a valid/ready handshake. Also tracks the per-frame maximum magnitude, which sets the auto threshold for the next frame.

Parameters:
- ROI_SIZE, 480, frame width and height in pixels (square ROI).
- PIXELS_IN_PER_CYCLE, 2, magnitudes per input beat.
- IN_WIDTH, 12, signed magnitude width.
- PORT_BITS, 128, packed output word width (1 bit per pixel).
- FIFO_DEPTH, 8, output FIFO depth in words (power of 2).
- THR_SHIFT, 2, auto threshold = previous-frame max >> THR_SHIFT.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- clk_en, input, 1, global clock enable; all state frozen when low.
- in_valid, input, 1, beat qualifier from the convolution stage.
- data_in, input, signed [IN_WIDTH-1:0] x PIXELS_IN_PER_CYCLE, magnitudes; element n is column conv_w+n.
- thr_sel, input, 1, 0 = use thr_in, 1 = auto threshold.
- thr_in, input, IN_WIDTH, manual threshold.
- ovf_clr, input, 1, clears the sticky overflow flag.
- out_data, output, PORT_BITS, packed edge word (FIFO head).
- out_valid, output, 1, FIFO not empty.
- out_last, output, 1, head word is the last word of a frame.
- out_ready, input, 1, consumer accepts the word.
- frame_done, output, 1, one-cycle pulse after the last word of a frame is pushed.
- frame_max, output, IN_WIDTH, max magnitude of the last completed frame.
- overflow, output, 1, sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, async): all outputs 0. FIFO empty, pack register 0, bit pointer 0, pixel counter 0, running max 0, prev max 0, state IDLE.
- clk_en low: no state changes, no push/pop. Outputs hold.
- Beats are accepted only on edges where clk_en=1 and in_valid=1. There is no input backpressure.
- Threshold:
  - Latched on the first beat of each frame (IDLE->ACTIVE).
  - Value is thr_in if thr_sel=1'b0, otherwise prev_max >> THR_SHIFT.
  - Mid-frame changes to thr_sel/thr_in are ignored.
  - Flag = (mag > thr), signed compare. Negative magnitudes yield 0.
- Packing:
  - Pixel p of the frame (raster order, row*ROI_SIZE+col) goes to bit p mod PORT_BITS of word p div PORT_BITS.
  - Beat elements land in ascending bit order.
  - PORT_BITS must be a multiple of PIXELS_IN_PER_CYCLE; words never split a beat.
- FSM:
  - IDLE: first beat -> ACTIVE. That beat is packed with the newly latched threshold.
  - ACTIVE: pack each beat. When the pixel counter reaches ROI_SIZE*ROI_SIZE, go to FLUSH if the word is partial, otherwise IDLE.
  - FLUSH: push the partial word with remaining high bits 0 and out_last=1, then go to IDLE. Exactly one cycle. Beats arriving in FLUSH are dropped (not possible with a conforming upstream).
- Word completion:
  - The completed word (including the completing beat's bits) is pushed on the same edge that samples the completing beat.
  - out_valid rises the following cycle (latency 1).
  - The pack register restarts at 0 for the next word.
- Frame end:
  - The frame-end push carries last=1.
  - On that push edge: frame_done pulses next cycle, frame_max <= max(running max, final beat), prev_max <= same, running max <= 0, pixel counter <= 0.
- FIFO:
  - First-word-fall-through. out_data/out_last are valid whenever out_valid=1.
  - Pop when out_valid & out_ready & clk_en.
  - Push when full with a simultaneous pop is allowed.
  - Push when full without a pop drops the word and sets overflow. Counters still advance so frame alignment is kept.
  - ovf_clr clears overflow; a simultaneous new overflow wins.
- Reset mid-frame: the partial word is discarded, the FIFO is emptied, and prev_max returns to 0.

Test Plan:
- ROI_SIZE=16, PORT_BITS=32, thr_sel=0, thr_in=100, data_in alternating {150,50} for 128 beats, out_ready=1 -> 8 words of 32'h55555555, out_last only on word 8, one frame_done pulse, frame_max=150.
- ROI_SIZE=10, PORT_BITS=32, all magnitudes 200, thr_in=0 -> 4 words: 3 x 32'hFFFFFFFF, then 32'h0000000F with out_last=1 (FLUSH path).
- Auto threshold: frame 1 max=400, THR_SHIFT=2; frame 2 magnitudes 100 and 101 -> threshold 100, flags 0 and 1 respectively. First frame after reset uses threshold 0.
- Backpressure: FIFO_DEPTH=4, out_ready=0 for a full ROI_SIZE=16 frame -> 4 words kept, overflow=1, frame_done still pulses. ovf_clr=1 -> overflow=0.
- Full FIFO with simultaneous push+pop -> no drop, overflow stays 0, word order preserved.
- clk_en=0 for 5 cycles mid-frame with in_valid=1 -> no bits packed, outputs frozen. rst_n low mid-frame -> out_valid=0, next frame starts at bit 0.
